// File: rtl/bcd_seg_shifter.sv
// rtl/bcd_seg_shifter.sv - binary to BCD (double dabble), 7-segment encode and serial shift to the segment chain
module bcd_seg_shifter #(
  parameter int BIN_BITS = 32,
  parameter int DIGITS   = 8,
  parameter int CLK_DIV  = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_BITS-1:0]   bin,
  input  logic [DIGITS-1:0]     point,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            sout
);

  localparam int BW = 4 * DIGITS;
  localparam int FW = 8 * DIGITS;
  localparam logic [7:0]  CONV_LAST  = 8'(BIN_BITS - 1);
  localparam logic [7:0]  SHIFT_LAST = 8'(FW - 1);
  localparam logic [15:0] HALF       = 16'(CLK_DIV);
  localparam logic [15:0] PER_LAST   = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CONV, ENC, SHIFT, LATCH} state_t;

  state_t              state;
  logic [BIN_BITS-1:0] bin_sr;
  logic [BW-1:0]       bcd_sr;
  logic [DIGITS-1:0]   point_r;
  logic                ovf;
  logic [FW-1:0]       frame_sr;
  logic [7:0]          bit_cnt;
  logic [15:0]         div_cnt;
  logic                seg_clk, seg_do, seg_pen, seg_clr;

  logic [BW-1:0]       adj;
  logic [FW-1:0]       frame_c;
  logic                seen;
  logic [3:0]          dig;
  logic [6:0]          glyph;

  assign sout = {seg_clk, seg_do, seg_pen, seg_clr};

  // Low seven bits of the active-low glyph; dp is merged in separately.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    adj = bcd_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  // Walk from the top digit down; a digit is blank until a nonzero digit has been seen.
  always_comb begin
    seen    = 1'b0;
    frame_c = '0;
    dig     = 4'd0;
    glyph   = 7'h7F;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig  = bcd_sr[4*i +: 4];
      seen = seen | (dig != 4'd0);
      if (ovf)                                   glyph = 7'h3F;
      else if (BLANK_LZ != 0 && !seen && i != 0) glyph = 7'h7F;
      else                                       glyph = seg7(dig);
      frame_c[8*i +: 8] = {~point_r[i], glyph};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      point_r  <= '0;
      ovf      <= 1'b0;
      frame_sr <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
      seg_clk  <= 1'b0;
      seg_do   <= 1'b0;
      seg_pen  <= 1'b0;
      seg_clr  <= 1'b0;
    end else begin
      seg_clr <= 1'b1;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin;
            point_r <= point;
            bcd_sr  <= '0;
            ovf     <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          {bcd_sr, bin_sr} <= {adj[BW-2:0], bin_sr, 1'b0};
          ovf              <= ovf | adj[BW-1];
          bit_cnt          <= bit_cnt + 8'd1;
          if (bit_cnt == CONV_LAST) state <= ENC;
        end
        ENC: begin
          bcd      <= bcd_sr;
          overflow <= ovf;
          seg_do   <= frame_c[FW-1];
          frame_sr <= {frame_c[FW-2:0], 1'b0};
          seg_clk  <= 1'b0;
          bit_cnt  <= '0;
          div_cnt  <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == PER_LAST) begin
            div_cnt <= '0;
            seg_clk <= 1'b0;
            if (bit_cnt == SHIFT_LAST) begin
              seg_do  <= 1'b0;
              seg_pen <= 1'b1;
              state   <= LATCH;
            end else begin
              bit_cnt  <= bit_cnt + 8'd1;
              seg_do   <= frame_sr[FW-1];
              frame_sr <= {frame_sr[FW-2:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
            seg_clk <= (div_cnt + 16'd1) >= HALF;
          end
        end
        LATCH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            seg_pen <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seg_shifter.sv
// tb/tb_bcd_seg_shifter.sv - scoreboard bench for bcd_seg_shifter (default and no-blanking instances)
module tb_bcd_seg_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] bin = '0;
  logic [7:0]  point = '0;
  logic        start0, start1;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [31:0] bcd0, bcd1;
  logic [3:0]  sout0, sout1;
  logic        m_busy, m_done, m_ovf;
  logic [31:0] m_bcd;
  logic [3:0]  m_sout;

  typedef struct {
    logic [63:0] frame;
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_ovf  = sel ? ovf1  : ovf0;
  assign m_bcd  = sel ? bcd1  : bcd0;
  assign m_sout = sel ? sout1 : sout0;

  bcd_seg_shifter #(.BIN_BITS(32), .DIGITS(8), .CLK_DIV(2), .BLANK_LZ(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .bin(bin), .point(point),
    .busy(busy0), .done(done0), .overflow(ovf0), .bcd(bcd0), .sout(sout0));

  bcd_seg_shifter #(.BIN_BITS(32), .DIGITS(8), .CLK_DIV(2), .BLANK_LZ(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .bin(bin), .point(point),
    .busy(busy1), .done(done1), .overflow(ovf1), .bcd(bcd1), .sout(sout1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [31:0] b, input logic [7:0] p, input logic do_push,
                       input logic [63:0] f, input logic [31:0] eb, input logic eo);
    @(negedge clk);
    bin   = b;
    point = p;
    start = 1'b1;
    if (do_push) q.push_back('{frame: f, bcd: eb, ovf: eo});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_q(input int target);
    int c;
    c = 0;
    while (q.size() > target && c < 3000) begin
      @(posedge clk);
      c++;
    end
    chk("wait_timeout", 64'(q.size() > target), 64'd0);
  endtask

  // Monitor: rebuilds the shifted frame from SEG_CLK rising edges and checks it on done.
  initial begin
    logic [63:0] cap;
    int nbits, bcnt, pcnt;
    logic pclk;
    exp_t e;
    cap = '0; nbits = 0; bcnt = 0; pcnt = 0; pclk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cap = '0; nbits = 0; bcnt = 0; pcnt = 0; pclk = 1'b0;
      end else begin
        if (m_sout[3] && !pclk) begin
          cap = {cap[62:0], m_sout[2]};
          nbits++;
        end
        pclk = m_sout[3];
        if (m_sout[1]) pcnt++;
        if (m_busy) bcnt++;
        if (m_done) begin
          if (q.size() == 0) begin
            chk("spurious_done", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk("frame",    cap, e.frame);
            chk("nbits",    64'(nbits), 64'd64);
            chk("bcd",      64'(m_bcd), 64'(e.bcd));
            chk("overflow", 64'(m_ovf), 64'(e.ovf));
            chk("busy_len", 64'(bcnt), 64'd291);
            chk("pen_len",  64'(pcnt), 64'd2);
          end
          cap = '0; nbits = 0; bcnt = 0; pcnt = 0;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sout0", 64'(sout0), 64'd0);
    chk("rst_sout1", 64'(sout1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_sout0", 64'(sout0), 64'h1);
    chk("rel_sout1", 64'(sout1), 64'h1);
    chk("rel_busy",  64'(busy0), 64'd0);
    chk("rel_bcd",   64'(bcd0),  64'd0);
    chk("rel_ovf",   64'(ovf0),  64'd0);

    issue(32'd12345678, 8'h00, 1'b1, 64'hF9A4B0999282F880, 32'h12345678, 1'b0);
    wait_q(0);
    issue(32'd0, 8'h01, 1'b1, 64'hFFFFFFFFFFFFFF40, 32'h0, 1'b0);
    wait_q(0);
    issue(32'd100000000, 8'h00, 1'b1, 64'hBFBFBFBFBFBFBFBF, 32'h0, 1'b1);
    wait_q(0);
    issue(32'd99999999, 8'h00, 1'b1, 64'h9090909090909090, 32'h99999999, 1'b0);
    wait_q(0);

    // start pulse during SHIFT must be ignored
    issue(32'd2024, 8'h04, 1'b1, 64'hFFFFFFFFA440A499, 32'h00002024, 1'b0);
    repeat (100) @(negedge clk);
    bin = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_q(0);

    // start held through the done cycle starts the next conversion
    issue(32'd5, 8'h00, 1'b1, 64'hFFFFFFFFFFFFFF92, 32'h5, 1'b0);
    @(negedge clk);
    bin = 32'd1000; point = 8'h00; start = 1'b1;
    q.push_back('{frame: 64'hFFFFFFFFF9C0C0C0, bcd: 32'h00001000, ovf: 1'b0});
    wait_q(1);
    #1 start = 1'b0;
    @(negedge clk);
    chk("held_busy", 64'(busy0), 64'd1);
    wait_q(0);

    // reset during SHIFT aborts with no done
    issue(32'd777, 8'h00, 1'b0, 64'h0, 32'h0, 1'b0);
    repeat (150) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_sout", 64'(sout0), 64'd0);
    chk("abort_busy", 64'(busy0), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_clr", 64'(sout0), 64'h1);
    issue(32'd1, 8'h00, 1'b1, 64'hFFFFFFFFFFFFFFF9, 32'h1, 1'b0);
    wait_q(0);

    sel = 1'b1;
    issue(32'd42, 8'h00, 1'b1, 64'hC0C0C0C0C0C099A4, 32'h00000042, 1'b0);
    wait_q(0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
